axil_wr_arb: RTL

Round-robin arbiter that shares one AXI-Lite write channel master between NUM_REQ DMA write requesters. It sits between the DMA engines and the write-channel block, on that block's i_wr_valid / i_wr_strb / i_wr_data / i_wr_addr / o_wr_ready side. It serialises write transactions, captures the granted payload and holds it stable for the whole AXI transaction. When the write response returns, it closes the requester's valid/ready handshake.

---
 rtl/axil_dma_pkg.sv | 16 +
 rtl/axil_rr_pick.sv | 33 +++
 rtl/axil_wr_arb.sv | 117 +++++++++++
 3 files changed

// File: rtl/axil_dma_pkg.sv
// Types and helpers shared by the AXI-Lite DMA arbitration blocks.
package axil_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } wr_arb_state_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axil_rr_pick.sv
// Combinational round-robin winner search, starting one past the last grant.
module axil_rr_pick
    import axil_dma_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int GRANT_WIDTH = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [GRANT_WIDTH-1:0] i_last,
    output logic                   o_any_req,
    output logic [GRANT_WIDTH-1:0] o_winner
);

    logic                   w_found;
    logic [GRANT_WIDTH-1:0] w_idx;

    assign o_any_req = |i_req;

    always_comb begin
        w_found  = 1'b0;
        w_idx    = '0;
        o_winner = '0;
        // Offsets 1..NUM_REQ visit every requester once, the last winner last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = GRANT_WIDTH'((int'(i_last) + i) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/axil_wr_arb.sv
// Round-robin arbiter sharing one AXI-Lite write channel among NUM_REQ requesters;
// the granted payload is captured in IDLE and held until the transaction closes.
module axil_wr_arb
    import axil_dma_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 64,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int GRANT_WIDTH = clog2_min1(NUM_REQ)
) (
    input  logic                             aclk,
    input  logic                             anreset,
    input  logic                             aenable,
    input  logic [NUM_REQ-1:0]               i_req_valid,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]    i_req_strb,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
    output logic [NUM_REQ-1:0]               o_req_ready,
    output logic                             o_wr_valid,
    output logic [STRB_WIDTH-1:0]            o_wr_strb,
    output logic [DATA_WIDTH-1:0]            o_wr_data,
    output logic [ADDR_WIDTH-1:0]            o_wr_addr,
    input  logic                             i_wr_ready,
    output logic [GRANT_WIDTH-1:0]           o_grant,
    output logic                             o_busy
);

    wr_arb_state_t          r_state;
    logic [GRANT_WIDTH-1:0] r_last_grant;
    logic [GRANT_WIDTH-1:0] r_grant;
    logic                   r_wr_valid;
    logic [NUM_REQ-1:0]     r_req_ready;
    logic                   r_busy;
    logic [STRB_WIDTH-1:0]  r_wr_strb;
    logic [DATA_WIDTH-1:0]  r_wr_data;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;

    logic                   w_any_req;
    logic [GRANT_WIDTH-1:0] w_winner;
    logic [STRB_WIDTH-1:0]  w_win_strb;
    logic [DATA_WIDTH-1:0]  w_win_data;
    logic [ADDR_WIDTH-1:0]  w_win_addr;
    logic [NUM_REQ-1:0]     w_grant_onehot;

    axil_rr_pick #(
        .NUM_REQ     (NUM_REQ),
        .GRANT_WIDTH (GRANT_WIDTH)
    ) u_pick (
        .i_req     (i_req_valid),
        .i_last    (r_last_grant),
        .o_any_req (w_any_req),
        .o_winner  (w_winner)
    );

    assign w_win_strb     = i_req_strb[int'(w_winner)*STRB_WIDTH +: STRB_WIDTH];
    assign w_win_data     = i_req_data[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
    assign w_win_addr     = i_req_addr[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_grant_onehot = NUM_REQ'(1) << r_grant;

    always_ff @(posedge aclk or negedge anreset) begin
        if (!anreset) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_WIDTH'(NUM_REQ - 1);
            r_grant      <= '0;
            r_wr_valid   <= 1'b0;
            r_req_ready  <= '0;
            r_busy       <= 1'b0;
            r_wr_strb    <= '0;
            r_wr_data    <= '0;
            r_wr_addr    <= '0;
        end else if (aenable) begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state      <= ISSUE;
                        r_grant      <= w_winner;
                        r_last_grant <= w_winner;
                        r_wr_strb    <= w_win_strb;
                        r_wr_data    <= w_win_data;
                        r_wr_addr    <= w_win_addr;
                        r_wr_valid   <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_state    <= WAIT;
                    r_wr_valid <= 1'b0;
                end
                WAIT: begin
                    // The write channel re-samples the payload here, so nothing else moves.
                    if (i_wr_ready) begin
                        r_state     <= DONE;
                        r_req_ready <= w_grant_onehot;
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_req_ready <= '0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_wr_valid  = r_wr_valid;
    assign o_wr_strb   = r_wr_strb;
    assign o_wr_data   = r_wr_data;
    assign o_wr_addr   = r_wr_addr;
    assign o_grant     = r_grant;
    assign o_busy      = r_busy;

endmodule
